uart_rx_monitor: RTL

UART_RX_MONITOR -- requirements
Module: uart_rx_monitor

---
 rtl/uart_rx_monitor.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx_monitor.sv
// uart_rx_monitor
//   Receives 8N1 serial bytes from the CPU's Tx line, queues them in a small
//   first-word-fall-through FIFO, and raises sticky status flags.
//
// Ports
//   clk         single clock, rising edge
//   rst_n       synchronous active-low reset
//   rx          asynchronous serial input, idle high, LSB first
//   rd_en       consumer pop request (ignored while rd_valid is low)
//   rd_data     FIFO head byte (8'h00 while empty)
//   rd_valid    FIFO non-empty
//   frame_err   sticky: a stop bit sampled low
//   overflow    sticky: a received byte was dropped because the FIFO was full
//   halt        sticky: HALT_BYTE was accepted into the FIFO
//   byte_count  bytes accepted into the FIFO, wraps modulo 2^16
module uart_rx_monitor #(
  parameter int          CLKS_PER_BIT    = 16,
  parameter int          FIFO_DEPTH_LOG2 = 3,
  parameter logic [7:0]  HALT_BYTE       = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  input  logic        rd_en,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        frame_err,
  output logic        overflow,
  output logic        halt,
  output logic [15:0] byte_count
);

  localparam int          L       = FIFO_DEPTH_LOG2;
  localparam int          DEPTH   = 1 << L;
  localparam logic [15:0] MID     = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] BIT_END = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state, state_n;
  logic [15:0] clk_cnt, clk_n;
  logic [2:0]  bit_cnt, bit_n;
  logic [7:0]  shreg, shreg_n;
  logic        bad_stop, bad_n;
  logic        push, ferr_set;

  // Synchronizer stage: rx_p0 -> rx_s; rx_d holds the previous rx_s so IDLE
  // starts a frame only on a falling edge, never on a line already low.
  logic        rx_p0, rx_s, rx_d;

  logic [L:0]  wr_ptr, rd_ptr;
  logic [7:0]  mem [DEPTH];
  logic        empty, full, pop, accept;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_p0    <= 1'b1;
      rx_s     <= 1'b1;
      rx_d     <= 1'b1;
      state    <= IDLE;
      clk_cnt  <= '0;
      bit_cnt  <= '0;
      bad_stop <= 1'b0;
    end else begin
      rx_p0    <= rx;
      rx_s     <= rx_p0;
      rx_d     <= rx_s;
      state    <= state_n;
      clk_cnt  <= clk_n;
      bit_cnt  <= bit_n;
      bad_stop <= bad_n;
    end
  end

  // Shift register is pure data; its contents are only used once a full
  // frame has been sampled, so it needs no reset.
  always_ff @(posedge clk) begin
    shreg <= shreg_n;
  end

  always_comb begin
    state_n  = state;
    clk_n    = clk_cnt + 16'd1;
    bit_n    = bit_cnt;
    shreg_n  = shreg;
    bad_n    = bad_stop;
    push     = 1'b0;
    ferr_set = 1'b0;
    unique case (state)
      IDLE: begin
        clk_n = '0;
        bit_n = '0;
        bad_n = 1'b0;
        if (!rx_s && rx_d) state_n = START;
      end
      START: begin
        if (clk_cnt == MID) begin
          clk_n   = '0;
          state_n = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (clk_cnt == BIT_END) begin
          clk_n            = '0;
          shreg_n[bit_cnt] = rx_s;
          if (bit_cnt == 3'd7) begin
            bit_n   = '0;
            state_n = STOP;
          end else begin
            bit_n = bit_cnt + 3'd1;
          end
        end
      end
      STOP: begin
        if (bad_stop) begin
          // Byte already discarded; just wait for the line to return high.
          clk_n = '0;
          if (rx_s) state_n = IDLE;
        end else if (clk_cnt == BIT_END) begin
          clk_n = '0;
          if (rx_s) begin
            push    = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_set = 1'b1;
            bad_n    = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // FIFO: extra pointer MSB distinguishes full from empty.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[L-1:0] == rd_ptr[L-1:0]) && (wr_ptr[L] != rd_ptr[L]);
  assign pop      = rd_en && !empty;
  assign accept   = push && (!full || pop);
  assign rd_valid = !empty;
  assign rd_data  = empty ? 8'h00 : mem[rd_ptr[L-1:0]];

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr[L-1:0]] <= shreg;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
      halt       <= 1'b0;
      byte_count <= '0;
    end else begin
      if (accept) begin
        wr_ptr     <= wr_ptr + 1'b1;
        byte_count <= byte_count + 16'd1;
        if (shreg == HALT_BYTE) halt <= 1'b1;
      end
      if (pop)                     rd_ptr    <= rd_ptr + 1'b1;
      if (push && full && !pop)    overflow  <= 1'b1;
      if (ferr_set)                frame_err <= 1'b1;
    end
  end

endmodule
